// File: rtl/ccff_chain_loader.sv
// Serialises packed bitstream words MSB-first into a configuration chain.
// An optional second pass recirculates the chain and compares CRC-16s.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       crc_out
);

    localparam int BC_W  = $clog2(WORD_W + 1);
    localparam int WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_LIM  = CNT_W'(WORDS);
    localparam logic [BC_W-1:0]  FULL_BUF  = BC_W'(WORD_W);
    localparam logic [15:0]      CRC_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t            state;
    logic              verify_lat;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic [WORD_W-1:0] word_buf;
    logic [BC_W-1:0]   buf_cnt;
    logic [15:0]       crc_load;
    logic [15:0]       crc_ver;
    logic              error_q;

    logic              load_shift;
    logic              last_load;
    logic              last_ver;
    logic              buf_free;
    logic              accept;
    logic [15:0]       crc_ver_next;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // NOTE: every signal in always_comb gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        load_shift   = 1'b0;
        buf_free     = 1'b0;
        s_ready      = 1'b0;
        shift_en     = 1'b0;
        ccff_head    = 1'b0;
        last_load    = 1'b0;
        last_ver     = 1'b0;
        crc_ver_next = crc_step(crc_ver, ccff_tail);

        load_shift = (state == LOAD) && (buf_cnt != '0) && (bit_cnt < LEN);
        last_load  = load_shift && (bit_cnt == LAST_BIT);
        last_ver   = (state == VERIFY) && (bit_cnt == LAST_BIT);
        buf_free   = (buf_cnt == '0) || ((buf_cnt == BC_W'(1)) && load_shift);

        // Gated by pReset so the chain never captures on the reset edge.
        s_ready  = !pReset && (state == LOAD) && (word_cnt < WORD_LIM) && buf_free;
        shift_en = !pReset && (load_shift || (state == VERIFY));

        ccff_head = (state == VERIFY) ? ccff_tail : word_buf[WORD_W-1];
    end

    assign accept  = s_valid && s_ready;
    assign busy    = (state == LOAD) || (state == VERIFY);
    assign done    = (state == DONE);
    assign error   = error_q;
    assign crc_out = crc_load;

    // NOTE: state is updated with non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of ordering.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state      <= IDLE;
            verify_lat <= 1'b0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            word_buf   <= '0;
            buf_cnt    <= '0;
            crc_load   <= CRC_INIT;
            crc_ver    <= CRC_INIT;
            error_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        verify_lat <= verify_en;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        word_buf   <= '0;
                        buf_cnt    <= '0;
                        crc_load   <= CRC_INIT;
                        error_q    <= 1'b0;
                    end
                end

                LOAD: begin
                    if (load_shift) begin
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        crc_load <= crc_step(crc_load, word_buf[WORD_W-1]);
                    end
                    if (accept) begin
                        word_buf <= s_data;
                        buf_cnt  <= FULL_BUF;
                        word_cnt <= word_cnt + CNT_W'(1);
                    end else if (load_shift) begin
                        word_buf <= word_buf << 1;
                        buf_cnt  <= buf_cnt - BC_W'(1);
                    end
                    // Leftover bits of the final word are dropped here.
                    if (last_load) begin
                        word_buf <= '0;
                        buf_cnt  <= '0;
                        bit_cnt  <= '0;
                        crc_ver  <= CRC_INIT;
                        state    <= verify_lat ? VERIFY : DONE;
                    end
                end

                VERIFY: begin
                    crc_ver <= crc_ver_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_ver) begin
                        bit_cnt <= '0;
                        error_q <= (crc_ver_next != crc_load);
                        state   <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: two instances (16- and 12-FF chains),
// each driving a behavioural chain model.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic pReset = 1'b1;

    // 16-FF instance
    logic        start16 = 1'b0, verify16 = 1'b0, s_valid16 = 1'b0;
    logic [7:0]  s_data16 = '0;
    logic        s_ready16, head16, shift_en16, tail16, busy16, done16, error16;
    logic [15:0] crc16;

    // 12-FF instance
    logic        start12 = 1'b0, verify12 = 1'b0, s_valid12 = 1'b0;
    logic [7:0]  s_data12 = '0;
    logic        s_ready12, head12, shift_en12, tail12, busy12, done12, error12;
    logic [15:0] crc12;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) dut16 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start16), .verify_en(verify16),
        .s_data(s_data16), .s_valid(s_valid16), .s_ready(s_ready16),
        .ccff_head(head16), .shift_en(shift_en16), .ccff_tail(tail16),
        .busy(busy16), .done(done16), .error(error16), .crc_out(crc16)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) dut12 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start12), .verify_en(verify12),
        .s_data(s_data12), .s_valid(s_valid12), .s_ready(s_ready12),
        .ccff_head(head12), .shift_en(shift_en12), .ccff_tail(tail12),
        .busy(busy12), .done(done12), .error(error12), .crc_out(crc12)
    );

    // Chain models: bit 0 is the head-side FF, the top bit drives ccff_tail.
    logic [15:0] chain16 = '0;
    logic [15:0] stuck16 = '0;
    logic [11:0] chain12 = '0;
    logic [31:0] log16 = '0;
    int          nshift16 = 0;
    int          nshift12 = 0;
    logic        log_clr = 1'b0;
    int          cyc = 0;

    assign tail16 = chain16[15];
    assign tail12 = chain12[11];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (shift_en16) chain16 <= {chain16[14:0], head16} | stuck16;
        if (shift_en12) chain12 <= {chain12[10:0], head12};
        if (log_clr) begin
            log16    <= '0;
            nshift16 <= 0;
            nshift12 <= 0;
        end else begin
            if (shift_en16) begin
                log16    <= {log16[30:0], head16};
                nshift16 <= nshift16 + 1;
            end
            if (shift_en12) nshift12 <= nshift12 + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int c0;
    int k;
    int ready_seen;
    logic [15:0] crc_a53c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of16(input logic [15:0] v);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // All tasks are entered and left on a falling edge.
    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge prog_clk);
        log_clr = 1'b0;
    endtask

    task automatic start_16(input logic v);
        start16  = 1'b1;
        verify16 = v;
        c0       = cyc;
        @(negedge prog_clk);
        start16 = 1'b0;
    endtask

    task automatic send16(input logic [7:0] d);
        int n;
        n = 0;
        s_data16  = d;
        s_valid16 = 1'b1;
        #1;
        while (!s_ready16 && n < 100) begin
            @(negedge prog_clk);
            #1;
            n++;
        end
        check("s_ready16_timeout", 32'(s_ready16), 32'd1);
        @(negedge prog_clk);
        s_valid16 = 1'b0;
    endtask

    task automatic send12(input logic [7:0] d);
        int n;
        n = 0;
        s_data12  = d;
        s_valid12 = 1'b1;
        #1;
        while (!s_ready12 && n < 100) begin
            @(negedge prog_clk);
            #1;
            n++;
        end
        check("s_ready12_timeout", 32'(s_ready12), 32'd1);
        @(negedge prog_clk);
        s_valid12 = 1'b0;
    endtask

    task automatic wait_done16();
        int n;
        n = 0;
        while (!done16 && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        check("done16_timeout", 32'(done16), 32'd1);
    endtask

    initial begin
        crc_a53c = crc_of16(16'hA53C);
        repeat (2) @(negedge prog_clk);

        // Reset state with pReset still high, then release.
        check("rst_shift_en", 32'(shift_en16), 32'd0);
        pReset = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready16), 32'd0);
        check("rst_head", 32'(head16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_error", 32'(error16), 32'd0);
        check("rst_crc_out", 32'(crc16), 32'hFFFF);
        @(negedge prog_clk);
        clear_log();

        // Basic load 0xA5, 0x3C with verify, continuous valid.
        start_16(1'b1);
        #1;
        check("basic_ready_cycle1", 32'(s_ready16), 32'd1);
        check("basic_busy", 32'(busy16), 32'd1);
        check("basic_no_shift_cycle1", 32'(shift_en16), 32'd0);
        send16(8'hA5);
        #1;
        check("basic_first_shift_latency", 32'(shift_en16), 32'd1);
        check("basic_first_head", 32'(head16), 32'd1);
        send16(8'h3C);
        wait_done16();
        check("basic_done_cycle", 32'(cyc - c0), 32'd34);
        check("basic_head_sequence", log16, 32'hA53CA53C);
        check("basic_shift_total", 32'(nshift16), 32'd32);
        check("basic_chain", 32'(chain16), 32'hA53C);
        check("basic_error", 32'(error16), 32'd0);
        check("basic_crc_out", 32'(crc16), 32'(crc_a53c));
        check("done_shift_en", 32'(shift_en16), 32'd0);
        check("done_s_ready", 32'(s_ready16), 32'd0);
        check("done_busy", 32'(busy16), 32'd0);

        // All-zero load without verify, restarted from DONE; a start during
        // LOAD must be ignored.
        clear_log();
        start_16(1'b0);
        send16(8'h00);
        start16 = 1'b1;
        @(negedge prog_clk);
        start16 = 1'b0;
        send16(8'h00);
        wait_done16();
        check("zero_crc_out", 32'(crc16), 32'h1D0F);
        check("zero_shift_total", 32'(nshift16), 32'd16);
        check("zero_chain", 32'(chain16), 32'h0000);
        check("zero_error", 32'(error16), 32'd0);

        // Fault: FF 5 stuck-at-1, zeros with verify.
        stuck16 = 16'h0020;
        clear_log();
        start_16(1'b1);
        send16(8'h00);
        send16(8'h00);
        wait_done16();
        check("fault_done", 32'(done16), 32'd1);
        check("fault_error", 32'(error16), 32'd1);
        check("fault_crc_out", 32'(crc16), 32'h1D0F);
        stuck16 = 16'h0000;

        // Backpressure: gap with s_valid low after the first word drains.
        clear_log();
        start_16(1'b0);
        send16(8'hA5);
        repeat (8) @(negedge prog_clk);
        #1;
        check("bp_gap_shift_en", 32'(shift_en16), 32'd0);
        check("bp_gap_ready", 32'(s_ready16), 32'd1);
        check("bp_gap_shift_count", 32'(nshift16), 32'd8);
        @(negedge prog_clk);
        #1;
        check("bp_gap2_shift_en", 32'(shift_en16), 32'd0);
        check("bp_gap2_busy", 32'(busy16), 32'd1);
        send16(8'h3C);
        wait_done16();
        check("bp_shift_total", 32'(nshift16), 32'd16);
        check("bp_chain", 32'(chain16), 32'hA53C);
        check("bp_head_sequence", 32'(log16[15:0]), 32'hA53C);
        check("bp_crc_out", 32'(crc16), 32'(crc_a53c));

        // Odd length on the 12-FF instance; a third word is held valid.
        clear_log();
        start12  = 1'b1;
        verify12 = 1'b0;
        @(negedge prog_clk);
        start12 = 1'b0;
        send12(8'hFF);
        send12(8'h0F);
        s_data12   = 8'hAA;
        s_valid12  = 1'b1;
        ready_seen = 0;
        k          = 0;
        #1;
        if (s_ready12) ready_seen++;
        while (!done12 && k < 100) begin
            @(negedge prog_clk);
            #1;
            if (s_ready12) ready_seen++;
            k++;
        end
        check("odd_done", 32'(done12), 32'd1);
        check("odd_ready_after_last_word", 32'(ready_seen), 32'd0);
        check("odd_shift_total", 32'(nshift12), 32'd12);
        check("odd_chain", 32'(chain12), 32'hFF0);
        @(negedge prog_clk);
        #1;
        check("odd_third_word_rejected", 32'(chain12), 32'hFF0);
        s_valid12 = 1'b0;
        @(negedge prog_clk);

        // Reset mid-operation after 7 LOAD shifts.
        clear_log();
        start_16(1'b1);
        send16(8'hA5);
        k = 0;
        while (nshift16 < 7 && k < 50) begin
            @(negedge prog_clk);
            k++;
        end
        check("mid_reached_7", 32'(nshift16), 32'd7);
        pReset = 1'b1;
        #1;
        check("mid_shift_en_drops", 32'(shift_en16), 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        #1;
        check("mid_no_shift_on_reset", 32'(nshift16), 32'd7);
        check("mid_busy", 32'(busy16), 32'd0);
        check("mid_done", 32'(done16), 32'd0);
        check("mid_s_ready", 32'(s_ready16), 32'd0);
        check("mid_head", 32'(head16), 32'd0);
        check("mid_crc_out", 32'(crc16), 32'hFFFF);
        @(negedge prog_clk);

        // Reset wins over a simultaneous start.
        pReset  = 1'b1;
        start16 = 1'b1;
        @(negedge prog_clk);
        pReset  = 1'b0;
        start16 = 1'b0;
        #1;
        check("reset_beats_start", 32'(busy16), 32'd0);
        @(negedge prog_clk);

        // Reload after the abandoned operation.
        clear_log();
        start_16(1'b1);
        send16(8'hA5);
        send16(8'h3C);
        wait_done16();
        check("reload_chain", 32'(chain16), 32'hA53C);
        check("reload_error", 32'(error16), 32'd0);
        check("reload_shift_total", 32'(nshift16), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
